lane_gather: RTL and testbench

- Reassembles a wide bus from a serial stream of fixed-width lane beats. It is the inverse of the wide-bus lane splitter, which drives 12-bit slices of a 41-bit bus into per-lane submodules.
- Per-word lane mask marks lanes as unconnected (empty). Empty lanes are skipped on input and zero-filled on output.
- Sits between a lane-serial producer and a wide-word consumer. Valid/ready on both sides.

---
 rtl/lane_gather_if.sv | 33 +++
 rtl/lane_gather.sv | 122 ++++++++++++
 tb/tb_lane_gather.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_gather_if.sv
// Lane-gather handshake bundle.
// Producer side: lane_mask, in_valid/in_ready, in_data, in_last.
// Consumer side: out_valid/out_ready, out_data, out_lanes.
// Status: err_short, err_long (one-cycle pulses), word_cnt (saturating).
// master = the environment (producer + consumer), slave = lane_gather.
interface lane_gather_if #(
    parameter int unsigned LANE_W    = 12,
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned OUT_W     = 41
);
    logic [NUM_LANES-1:0] lane_mask;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANE_W-1:0]    in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [NUM_LANES-1:0] out_lanes;
    logic                 err_short;
    logic                 err_long;
    logic [15:0]          word_cnt;

    modport master (
        output lane_mask, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_lanes, err_short, err_long, word_cnt
    );

    modport slave (
        input  lane_mask, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_lanes, err_short, err_long, word_cnt
    );
endinterface

// File: rtl/lane_gather.sv
// Reassembles a wide word from a serial stream of LANE_W-bit lane beats.
// Ports: clk, rst_n (async active-low), bus (lane_gather_if.slave):
//   input side  lane_mask/in_valid/in_ready/in_data/in_last,
//   output side out_valid/out_ready/out_data/out_lanes,
//   status      err_short/err_long pulses, word_cnt (saturating).
// Beats fill the enabled lanes lowest-first; disabled/unfilled lanes and bits
// above NUM_LANES*LANE_W read as zero. Input and output phases never overlap.
module lane_gather #(
    parameter int unsigned LANE_W    = 12,
    parameter int unsigned NUM_LANES = 3,
    parameter int unsigned OUT_W     = 41
) (
    input  logic           clk,
    input  logic           rst_n,
    lane_gather_if.slave   bus
);
    localparam int unsigned DATA_W = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t               state;
    logic [NUM_LANES-1:0] word_mask;
    logic [NUM_LANES-1:0] filled;
    logic [DATA_W-1:0]    asm_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 err_short_q;
    logic                 err_long_q;
    logic [15:0]          word_cnt_q;

    logic [NUM_LANES-1:0] eff_mask_c;
    logic [NUM_LANES-1:0] rem_c;
    logic [NUM_LANES-1:0] pick_c;
    logic [NUM_LANES-1:0] rem_after_c;
    logic [DATA_W-1:0]    asm_next_c;
    logic                 accept_c;
    logic                 final_c;
    logic                 done_c;

    // Target lane = lowest enabled lane not yet written this word.
    // In IDLE the live mask applies (zero means all lanes); afterwards the latched one.
    always_comb begin
        eff_mask_c = word_mask;
        if (state == IDLE) begin
            eff_mask_c = (bus.lane_mask == '0) ? {NUM_LANES{1'b1}} : bus.lane_mask;
        end
        rem_c       = eff_mask_c & ~filled;
        pick_c      = rem_c & (~rem_c + NUM_LANES'(1));
        rem_after_c = rem_c & ~pick_c;
        accept_c    = bus.in_valid && in_ready_q;
        final_c     = (rem_after_c == '0);
        done_c      = accept_c && (final_c || bus.in_last);
        asm_next_c  = asm_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (pick_c[i]) begin
                asm_next_c[i*LANE_W +: LANE_W] = bus.in_data;
            end
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_mask   <= '0;
            filled      <= '0;
            asm_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (accept_c) begin
                        if (state == IDLE) begin
                            word_mask <= eff_mask_c;
                        end
                        asm_q  <= asm_next_c;
                        filled <= filled | pick_c;
                        if (done_c) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            err_short_q <= bus.in_last && !final_c;
                            err_long_q  <= final_c && !bus.in_last;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        asm_q       <= '0;
                        filled      <= '0;
                        if (word_cnt_q != 16'hFFFF) begin
                            word_cnt_q <= word_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = OUT_W'(asm_q);
    assign bus.out_lanes = filled;
    assign bus.err_short = err_short_q;
    assign bus.err_long  = err_long_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_lane_gather.sv
// Self-checking bench for lane_gather: directed words with literal expectations
// plus randomized words, all compared every cycle against a transaction-level model.
module tb_lane_gather;
    localparam int unsigned LANE_W    = 12;
    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned OUT_W     = 41;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

    lane_gather_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .OUT_W(OUT_W)) bus ();

    lane_gather #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic                 exp_in_ready  = 1'b0;
    logic                 exp_out_valid = 1'b0;
    logic                 exp_err_short = 1'b0;
    logic                 exp_err_long  = 1'b0;
    logic [15:0]          exp_cnt       = '0;
    logic [OUT_W-1:0]     exp_data      = '0;
    logic [NUM_LANES-1:0] exp_lanes     = '0;
    bit                   m_busy        = 1'b0;
    int                   m_beats       = 0;
    int                   m_order[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_in_ready  = 1'b0;
            exp_out_valid = 1'b0;
            exp_err_short = 1'b0;
            exp_err_long  = 1'b0;
            exp_cnt       = '0;
            exp_data      = '0;
            exp_lanes     = '0;
            m_busy        = 1'b0;
            m_beats       = 0;
            m_order.delete();
        end else begin
            exp_err_short = 1'b0;
            exp_err_long  = 1'b0;
            if (exp_out_valid) begin
                if (bus.out_ready) begin
                    exp_out_valid = 1'b0;
                    exp_cnt       = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
                    exp_data      = '0;
                    exp_lanes     = '0;
                    m_busy        = 1'b0;
                end
            end else if (bus.in_valid && exp_in_ready) begin
                if (!m_busy) begin
                    logic [NUM_LANES-1:0] m;
                    m = (bus.lane_mask == '0) ? {NUM_LANES{1'b1}} : bus.lane_mask;
                    m_order.delete();
                    for (int i = 0; i < NUM_LANES; i++) if (m[i]) m_order.push_back(i);
                    m_beats = 0;
                    m_busy  = 1'b1;
                end
                exp_data[m_order[m_beats]*LANE_W +: LANE_W] = bus.in_data;
                exp_lanes[m_order[m_beats]] = 1'b1;
                m_beats++;
                if (m_beats == m_order.size() || bus.in_last) begin
                    exp_out_valid = 1'b1;
                    exp_err_short = bus.in_last && (m_beats < m_order.size());
                    exp_err_long  = !bus.in_last && (m_beats == m_order.size());
                end
            end
            exp_in_ready = !exp_out_valid;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("in_ready", 64'(bus.in_ready), 64'(exp_in_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_out_valid));
        chk("err_short", 64'(bus.err_short), 64'(exp_err_short));
        chk("err_long", 64'(bus.err_long), 64'(exp_err_long));
        chk("word_cnt", 64'(bus.word_cnt), 64'(exp_cnt));
        if (exp_out_valid || !rst_n) begin
            chk("out_data", 64'(bus.out_data), 64'(exp_data));
            chk("out_lanes", 64'(bus.out_lanes), 64'(exp_lanes));
        end
    end

    // Consumer ready, updated just after the active edge.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'($urandom_range(0, 1));
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Present one beat from a negedge; returns at the negedge after it is accepted.
    task automatic send_beat(input logic [LANE_W-1:0] d, input logic last,
                             input logic [NUM_LANES-1:0] mask);
        logic rdy;
        int   n = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = last;
        bus.lane_mask = mask;
        forever begin
            rdy = bus.in_ready;
            @(negedge clk);
            if (rdy) break;
            n++;
            if (n > 500) begin
                chk("beat_timeout", 64'd0, 64'd1);
                break;
            end
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'($urandom_range(0, 1));
        bus.in_data   = LANE_W'($urandom);
        bus.lane_mask = NUM_LANES'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_word(input string nm, input logic [OUT_W-1:0] d,
                            input logic [NUM_LANES-1:0] l, input logic es, input logic el);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_data"}, 64'(bus.out_data), 64'(d));
        chk({nm, "_lanes"}, 64'(bus.out_lanes), 64'(l));
        chk({nm, "_err_short"}, 64'(bus.err_short), 64'(es));
        chk({nm, "_err_long"}, 64'(bus.err_long), 64'(el));
    endtask

    initial begin
        logic [OUT_W-1:0] held;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.lane_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Full word, all lanes.
        send_beat(12'h123, 1'b0, 3'b111);
        send_beat(12'h456, 1'b0, 3'b111);
        send_beat(12'h789, 1'b1, 3'b111);
        chk_word("w1", 41'h0789456123, 3'b111, 1'b0, 1'b0);
        @(negedge clk);
        chk("w1_cnt", 64'(bus.word_cnt), 64'd1);

        // Lane 1 disabled.
        send_beat(12'hAAA, 1'b0, 3'b101);
        send_beat(12'hBBB, 1'b1, 3'b101);
        chk_word("w2", 41'h0BBB000AAA, 3'b101, 1'b0, 1'b0);
        wait_idle();

        // Short word.
        send_beat(12'h111, 1'b0, 3'b111);
        send_beat(12'h222, 1'b1, 3'b111);
        chk_word("w3", 41'h0000222111, 3'b011, 1'b1, 1'b0);
        wait_idle();

        // Long word with consumer stall.
        rdy_mode = 2;
        send_beat(12'h321, 1'b0, 3'b111);
        send_beat(12'h654, 1'b0, 3'b111);
        send_beat(12'h987, 1'b0, 3'b111);
        chk_word("w4", 41'h0987654321, 3'b111, 1'b0, 1'b1);
        held = bus.out_data;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_data", 64'(bus.out_data), 64'(held));
        end
        rdy_mode = 1;
        wait_idle();
        chk("w4_cnt", 64'(bus.word_cnt), 64'd4);

        // Reset mid-word.
        send_beat(12'h0F1, 1'b0, 3'b111);
        send_beat(12'h0F2, 1'b0, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data", 64'(bus.out_data), 64'd0);
        chk("midrst_lanes", 64'(bus.out_lanes), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_cnt", 64'(bus.word_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(12'h001, 1'b0, 3'b111);
        send_beat(12'h002, 1'b0, 3'b111);
        send_beat(12'h003, 1'b1, 3'b111);
        chk_word("w5", 41'h0003002001, 3'b111, 1'b0, 1'b0);
        wait_idle();

        // Zero mask means all lanes; later mask changes ignored.
        send_beat(12'hA01, 1'b0, 3'b000);
        send_beat(12'hA02, 1'b0, 3'b001);
        send_beat(12'hA03, 1'b1, 3'b010);
        chk_word("w6", 41'h0A03A02A01, 3'b111, 1'b0, 1'b0);
        wait_idle();
        chk("w6_cnt", 64'(bus.word_cnt), 64'd2);

        // Randomized words.
        rdy_mode = 0;
        for (int w = 0; w < 300; w++) begin
            logic [NUM_LANES-1:0] mask, eff;
            int nl, nb;
            mask = NUM_LANES'($urandom_range(0, 7));
            eff  = (mask == '0) ? {NUM_LANES{1'b1}} : mask;
            nl   = $countones(eff);
            nb   = $urandom_range(1, nl);
            for (int j = 0; j < nb; j++) begin
                logic last;
                last = 1'b0;
                if (j == nb - 1) last = (nb < nl) ? 1'b1 : 1'($urandom_range(0, 1));
                send_beat(LANE_W'($urandom), last,
                          (j == 0) ? mask : NUM_LANES'($urandom_range(0, 7)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        rdy_mode = 1;
        repeat (20) @(negedge clk);
        chk("final_idle", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
